// File: rtl/uart_cmd_bridge.sv
// Debug-host bridge: decodes byte-serial 'W'/'R' commands from the UART into single bus accesses
// and returns the reply bytes. Defining UART_CMD_TIMEOUT_EN adds an inter-byte timeout abort.
module uart_cmd_bridge #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    output logic              clr_rx_rdy,
    input  logic              tx_ready,
    input  logic              tx_done,
    output logic              trmt,
    output logic [7:0]        tx_data,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              busy,
    output logic              cmd_err
);
    localparam int         ABYTES   = ADDR_W / 8;
    localparam int         DBYTES   = DATA_W / 8;
    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] RSP_OK   = 8'h4B;
    localparam logic [7:0] RSP_BAD  = 8'h3F;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_BUS_REQ,
        S_BUS_WAIT,
        S_TX_LOAD,
        S_TX_WAIT
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   reply_q, reply_d;
    logic [2:0]          rem_q, rem_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                trmt_q, trmt_d;
    logic                clr_q, clr_d;
    logic                err_q, err_d;
    logic                rx_take;

`ifdef UART_CMD_TIMEOUT_EN
    localparam logic [7:0] RSP_TIMEOUT = 8'h54;
    localparam int         TO_W        = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0]       to_q, to_d;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC != 0);
`endif

    // Single-byte replies sit in the top byte of the reply shift register.
    function automatic logic [DATA_W-1:0] single_byte(input logic [7:0] b);
        return DATA_W'(b) << (DATA_W - 8);
    endfunction

    // NOTE: every *_d is given its hold value first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        reply_d   = reply_q;
        rem_d     = rem_q;
        tx_data_d = tx_data_q;
        trmt_d    = 1'b0;
        err_d     = 1'b0;
        // rx_rdy is still high in the cycle after a clear, so that cycle is skipped.
        rx_take   = rx_rdy && !clr_q &&
                    (state_q == S_IDLE || state_q == S_ADDR || state_q == S_DATA);
        clr_d     = rx_take;

        case (state_q)
            S_IDLE: begin
                if (rx_take) begin
                    if (rx_data == OP_WRITE || rx_data == OP_READ) begin
                        we_d    = (rx_data == OP_WRITE);
                        cnt_d   = 2'(ABYTES - 1);
                        state_d = S_ADDR;
                    end else begin
                        err_d   = 1'b1;
                        reply_d = single_byte(RSP_BAD);
                        rem_d   = 3'd1;
                        state_d = S_TX_LOAD;
                    end
                end
            end
            S_ADDR: begin
                if (rx_take) begin
                    addr_d = ADDR_W'({addr_q, rx_data});
                    if (cnt_q == 2'd0) begin
                        if (we_q) begin
                            cnt_d   = 2'(DBYTES - 1);
                            state_d = S_DATA;
                        end else begin
                            state_d = S_BUS_REQ;
                        end
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end
            end
            S_DATA: begin
                if (rx_take) begin
                    wdata_d = DATA_W'({wdata_q, rx_data});
                    if (cnt_q == 2'd0) state_d = S_BUS_REQ;
                    else               cnt_d   = cnt_q - 2'd1;
                end
            end
            S_BUS_REQ: begin
                if (bus_gnt) begin
                    if (we_q) begin
                        reply_d = single_byte(RSP_OK);
                        rem_d   = 3'd1;
                        state_d = S_TX_LOAD;
                    end else if (bus_rvalid) begin
                        reply_d = bus_rdata;
                        rem_d   = 3'(DBYTES);
                        state_d = S_TX_LOAD;
                    end else begin
                        state_d = S_BUS_WAIT;
                    end
                end
            end
            S_BUS_WAIT: begin
                if (bus_rvalid) begin
                    reply_d = bus_rdata;
                    rem_d   = 3'(DBYTES);
                    state_d = S_TX_LOAD;
                end
            end
            S_TX_LOAD: begin
                tx_data_d = reply_q[DATA_W-1 -: 8];
                if (tx_ready) begin
                    trmt_d  = 1'b1;
                    state_d = S_TX_WAIT;
                end
            end
            S_TX_WAIT: begin
                if (tx_done) begin
                    if (rem_q > 3'd1) begin
                        reply_d = reply_q << 8;
                        rem_d   = rem_q - 3'd1;
                        state_d = S_TX_LOAD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef UART_CMD_TIMEOUT_EN
        to_d = '0;
        if (state_q == S_ADDR || state_q == S_DATA) begin
            if (rx_take) begin
                to_d = '0;
            end else if (to_q == TO_W'(TIMEOUT_CYC - 1)) begin
                err_d   = 1'b1;
                reply_d = single_byte(RSP_TIMEOUT);
                rem_d   = 3'd1;
                state_d = S_TX_LOAD;
            end else begin
                to_d = to_q + TO_W'(1);
            end
        end
`endif
    end

    // NOTE: state updates use non-blocking '<=' so every flop samples pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            reply_q   <= '0;
            rem_q     <= '0;
            tx_data_q <= '0;
            trmt_q    <= 1'b0;
            clr_q     <= 1'b0;
            err_q     <= 1'b0;
`ifdef UART_CMD_TIMEOUT_EN
            to_q      <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            reply_q   <= reply_d;
            rem_q     <= rem_d;
            tx_data_q <= tx_data_d;
            trmt_q    <= trmt_d;
            clr_q     <= clr_d;
            err_q     <= err_d;
`ifdef UART_CMD_TIMEOUT_EN
            to_q      <= to_d;
`endif
        end
    end

    assign clr_rx_rdy = clr_q;
    assign trmt       = trmt_q;
    assign tx_data    = tx_data_q;
    assign bus_req    = (state_q == S_BUS_REQ);
    assign bus_we     = we_q;
    assign bus_addr   = addr_q;
    assign bus_wdata  = wdata_q;
    assign busy       = (state_q != S_IDLE);
    assign cmd_err    = err_q;

endmodule
